// File: rtl/traffic_intersection.sv
// traffic_intersection: N-way signal controller cycling one approach at a time
// through GREEN, YELLOW and ALL-RED, timed by an external 1-cycle tick strobe.
// Green times are per direction; yellow and all-red times are shared. With
// SKIP_IDLE set, approaches without demand are passed over.
module traffic_intersection #(
  parameter int N_WAY      = 4,
  parameter int DIR_W      = 2,
  parameter int TW         = 5,
  parameter int DEF_GREEN  = 10,
  parameter int DEF_YELLOW = 3,
  parameter int DEF_ALLRED = 1,
  parameter int SKIP_IDLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               run,
  input  logic [N_WAY-1:0]   demand,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_field,
  input  logic [DIR_W-1:0]   cfg_dir,
  input  logic [TW-1:0]      cfg_data,
  output logic [2*N_WAY-1:0] light,
  output logic [DIR_W-1:0]   active,
  output logic [1:0]         phase,
  output logic [TW-1:0]      remaining
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;
  localparam logic [1:0] S_ALLRED = 2'd3;

  localparam int N_SLOT = 2 ** DIR_W;

  logic [1:0]       state;
  logic [DIR_W-1:0] act;
  logic [TW-1:0]    cnt;

  // One slot per encodable direction so any cfg_dir/act value indexes the
  // table at its natural width; slots at or above N_WAY are never written.
  logic [TW-1:0]    green_t [N_SLOT];
  logic [TW-1:0]    yellow_t;
  logic [TW-1:0]    allred_t;

  logic [2*N_WAY-1:0] demand_rot;
  logic [DIR_W-1:0]   next_dir;
  int                 first_hit;
  int                 next_sum;

  // A programmed time T gives max(T,1) ticks, so the counter starts at max(T,1)-1.
  function automatic logic [TW-1:0] load_val(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Next direction: rotate demand so bit 0 is the slot after act, take the
  // lowest set bit; no demand (or no skipping) falls back to act+1.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    demand_rot = {demand, demand} >> (act + 1'b1);
    first_hit  = 0;
    if (SKIP_IDLE != 0) begin
      for (int k = N_WAY - 1; k >= 0; k--) begin
        if (demand_rot[k]) first_hit = k;
      end
    end
    next_sum = int'(act) + 1 + first_hit;
    if (next_sum >= N_WAY) next_sum = next_sum - N_WAY;
    next_dir = DIR_W'(next_sum);
  end

  // Time registers: defaults on reset, out-of-range or field-3 writes dropped.
  always_ff @(posedge clk) begin
    // NOTE: the time table is reset explicitly because its defaults are
    // architectural state, not don't-care storage.
    if (rst) begin
      for (int i = 0; i < N_SLOT; i++) green_t[i] <= TW'(DEF_GREEN);
      yellow_t <= TW'(DEF_YELLOW);
      allred_t <= TW'(DEF_ALLRED);
    end else if (cfg_we) begin
      case (cfg_field)
        2'd0:    if (int'(cfg_dir) < N_WAY) green_t[cfg_dir] <= cfg_data;
        2'd1:    yellow_t <= cfg_data;
        2'd2:    allred_t <= cfg_data;
        default: ;
      endcase
    end
  end

  // Phase sequencer; loads read the time table before any same-cycle write lands.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
    if (rst) begin
      state <= S_IDLE;
      act   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (run) begin
            state <= S_GREEN;
            cnt   <= load_val(green_t[act]);
          end
        end
        S_GREEN: begin
          if (tick) begin
            if (cnt == '0 || !run) begin
              state <= S_YELLOW;
              cnt   <= load_val(yellow_t);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_YELLOW: begin
          if (tick) begin
            if (cnt == '0) begin
              state <= S_ALLRED;
              cnt   <= load_val(allred_t);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          if (tick) begin
            if (cnt == '0) begin
              act <= next_dir;
              if (run) begin
                state <= S_GREEN;
                cnt   <= load_val(green_t[next_dir]);
              end else begin
                state <= S_IDLE;
                cnt   <= '0;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Colour decode from registered state: only the active approach leaves red.
  always_comb begin
    light = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (act == DIR_W'(i)) begin
        if (state == S_GREEN)  light[2*i +: 2] = 2'b01;
        if (state == S_YELLOW) light[2*i +: 2] = 2'b10;
      end
    end
  end

  assign active    = act;
  assign phase     = state;
  assign remaining = cnt;

endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: drives a round-robin and a demand-skipping instance
// with identical stimulus. A reference model predicts every cycle's outputs
// into per-instance queues; directed checks pin the key phase boundaries.
module tb_traffic_intersection;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic [3:0] demand = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_field = '0;
  logic [2:0] cfg_dir = '0;
  logic [4:0] cfg_data = '0;

  logic [7:0] rr_light, sk_light;
  logic [2:0] rr_active, sk_active;
  logic [1:0] rr_phase, sk_phase;
  logic [4:0] rr_rem, sk_rem;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  traffic_intersection #(.N_WAY(4), .DIR_W(3), .TW(5), .DEF_GREEN(10), .DEF_YELLOW(3),
                         .DEF_ALLRED(1), .SKIP_IDLE(0)) u_rr (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .demand(demand),
    .cfg_we(cfg_we), .cfg_field(cfg_field), .cfg_dir(cfg_dir), .cfg_data(cfg_data),
    .light(rr_light), .active(rr_active), .phase(rr_phase), .remaining(rr_rem));

  traffic_intersection #(.N_WAY(4), .DIR_W(3), .TW(5), .DEF_GREEN(10), .DEF_YELLOW(3),
                         .DEF_ALLRED(1), .SKIP_IDLE(1)) u_sk (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .demand(demand),
    .cfg_we(cfg_we), .cfg_field(cfg_field), .cfg_dir(cfg_dir), .cfg_data(cfg_data),
    .light(sk_light), .active(sk_active), .phase(sk_phase), .remaining(sk_rem));

  typedef struct packed {
    logic [1:0] phase;
    logic [2:0] active;
    logic [4:0] rem;
    logic [7:0] light;
  } exp_t;

  typedef struct packed {
    logic [1:0]      phase;
    logic [2:0]      active;
    logic [4:0]      cnt;
    logic [3:0][4:0] green;
    logic [4:0]      yellow;
    logic [4:0]      allred;
  } model_t;

  exp_t   q_rr[$];
  exp_t   q_sk[$];
  model_t m_rr;
  model_t m_sk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ticks_to_cnt(input logic [4:0] t);
    return (t == 5'd0) ? 5'd0 : t - 5'd1;
  endfunction

  function automatic logic [2:0] model_next(input logic [2:0] a, input logic [3:0] d, input bit skip);
    int i;
    if (skip) begin
      for (int k = 1; k <= 4; k++) begin
        i = (int'(a) + k) % 4;
        if (d[i]) return 3'(i);
      end
    end
    return 3'((int'(a) + 1) % 4);
  endfunction

  function automatic model_t model_step(input model_t m, input bit skip);
    model_t n;
    n = m;
    if (rst) begin
      n.phase  = 2'd0;
      n.active = 3'd0;
      n.cnt    = 5'd0;
      for (int i = 0; i < 4; i++) n.green[i] = 5'd10;
      n.yellow = 5'd3;
      n.allred = 5'd1;
      return n;
    end
    case (m.phase)
      2'd0: if (run) begin n.phase = 2'd1; n.cnt = ticks_to_cnt(m.green[m.active[1:0]]); end
      2'd1: if (tick) begin
        if (m.cnt == 0 || !run) begin n.phase = 2'd2; n.cnt = ticks_to_cnt(m.yellow); end
        else n.cnt = m.cnt - 5'd1;
      end
      2'd2: if (tick) begin
        if (m.cnt == 0) begin n.phase = 2'd3; n.cnt = ticks_to_cnt(m.allred); end
        else n.cnt = m.cnt - 5'd1;
      end
      default: if (tick) begin
        if (m.cnt == 0) begin
          n.active = model_next(m.active, demand, skip);
          if (run) begin n.phase = 2'd1; n.cnt = ticks_to_cnt(m.green[n.active[1:0]]); end
          else begin n.phase = 2'd0; n.cnt = 5'd0; end
        end else n.cnt = m.cnt - 5'd1;
      end
    endcase
    if (cfg_we) begin
      if (cfg_field == 2'd0 && cfg_dir < 3'd4) n.green[cfg_dir[1:0]] = cfg_data;
      if (cfg_field == 2'd1) n.yellow = cfg_data;
      if (cfg_field == 2'd2) n.allred = cfg_data;
    end
    return n;
  endfunction

  function automatic exp_t model_out(input model_t m);
    exp_t e;
    e.phase  = m.phase;
    e.active = m.active;
    e.rem    = m.cnt;
    e.light  = '0;
    if (m.phase == 2'd1) e.light[2*m.active[1:0] +: 2] = 2'b01;
    if (m.phase == 2'd2) e.light[2*m.active[1:0] +: 2] = 2'b10;
    return e;
  endfunction

  function automatic int non_red(input logic [7:0] l);
    int c = 0;
    for (int i = 0; i < 4; i++) if (l[2*i +: 2] != 2'b00) c++;
    return c;
  endfunction

  // One clock: predict from the inputs now applied, let the edge pass, compare at negedge.
  task automatic cycle();
    exp_t e;
    m_rr = model_step(m_rr, 1'b0);
    m_sk = model_step(m_sk, 1'b1);
    q_rr.push_back(model_out(m_rr));
    q_sk.push_back(model_out(m_sk));
    @(posedge clk);
    @(negedge clk);
    e = q_rr.pop_front();
    check("rr.phase", rr_phase, e.phase);
    check("rr.active", rr_active, e.active);
    check("rr.remaining", rr_rem, e.rem);
    check("rr.light", rr_light, e.light);
    check("rr.one_lit", (non_red(rr_light) <= 1), 1);
    e = q_sk.pop_front();
    check("sk.phase", sk_phase, e.phase);
    check("sk.active", sk_active, e.active);
    check("sk.remaining", sk_rem, e.rem);
    check("sk.light", sk_light, e.light);
    check("sk.one_lit", (non_red(sk_light) <= 1), 1);
  endtask

  // Tick every fourth clock.
  task automatic do_ticks(input int n);
    repeat (n) begin
      tick = 1'b0;
      repeat (3) cycle();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
    end
  endtask

  task automatic cfg_write(input logic [1:0] f, input logic [2:0] d, input logic [4:0] v);
    cfg_we = 1'b1; cfg_field = f; cfg_dir = d; cfg_data = v;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic expect_rr(input string tag, input logic [1:0] ph, input logic [2:0] a, input logic [4:0] r);
    check({tag, ".phase"}, rr_phase, ph);
    check({tag, ".active"}, rr_active, a);
    check({tag, ".remaining"}, rr_rem, r);
  endtask

  task automatic expect_sk(input string tag, input logic [1:0] ph, input logic [2:0] a, input logic [4:0] r);
    check({tag, ".phase"}, sk_phase, ph);
    check({tag, ".active"}, sk_active, a);
    check({tag, ".remaining"}, sk_rem, r);
  endtask

  initial begin
    // Reset and idle.
    repeat (2) cycle();
    expect_rr("reset", 2'd0, 3'd0, 5'd0);
    check("reset.light", rr_light, 8'h00);
    rst = 1'b0;
    cycle();
    expect_rr("idle_no_run", 2'd0, 3'd0, 5'd0);

    // Default cycle.
    run = 1'b1;
    cycle();
    expect_rr("go_green0", 2'd1, 3'd0, 5'd9);
    check("go_green0.light", rr_light, 8'h01);
    do_ticks(9);
    expect_rr("green0_last", 2'd1, 3'd0, 5'd0);
    do_ticks(1);
    expect_rr("yellow0", 2'd2, 3'd0, 5'd2);
    check("yellow0.light", rr_light, 8'h02);
    do_ticks(3);
    expect_rr("allred0", 2'd3, 3'd0, 5'd0);
    check("allred0.light", rr_light, 8'h00);
    do_ticks(1);
    expect_rr("green1", 2'd1, 3'd1, 5'd9);
    check("green1.light", rr_light, 8'h04);
    do_ticks(42);
    expect_rr("wrap_green0", 2'd1, 3'd0, 5'd9);

    // Programming, including a dropped out-of-range direction and field 3.
    cfg_write(2'd0, 3'd2, 5'd4);
    cfg_write(2'd1, 3'd0, 5'd0);
    cfg_write(2'd2, 3'd0, 5'd2);
    cfg_write(2'd0, 3'd5, 5'd7);
    cfg_write(2'd3, 3'd0, 5'd9);
    do_ticks(10);
    expect_rr("prog_yellow0", 2'd2, 3'd0, 5'd0);
    do_ticks(1);
    expect_rr("prog_allred0", 2'd3, 3'd0, 5'd1);
    do_ticks(2);
    expect_rr("prog_green1", 2'd1, 3'd1, 5'd9);
    do_ticks(13);
    expect_rr("prog_green2", 2'd1, 3'd2, 5'd3);
    do_ticks(3);
    expect_rr("prog_green2_last", 2'd1, 3'd2, 5'd0);
    // Tick and yellow write together: the phase loads the old yellow time.
    tick = 1'b0;
    repeat (3) cycle();
    tick = 1'b1; cfg_we = 1'b1; cfg_field = 2'd1; cfg_data = 5'd2;
    cycle();
    tick = 1'b0; cfg_we = 1'b0;
    expect_rr("same_cycle_yellow2", 2'd2, 3'd2, 5'd0);
    do_ticks(1);
    expect_rr("prog_allred2", 2'd3, 3'd2, 5'd1);
    do_ticks(2);
    expect_rr("prog_green3", 2'd1, 3'd3, 5'd9);
    do_ticks(10);
    expect_rr("new_yellow3", 2'd2, 3'd3, 5'd1);

    // Reset during YELLOW with tick and a config write in the same cycle.
    rst = 1'b1; tick = 1'b1; cfg_we = 1'b1; cfg_field = 2'd1; cfg_data = 5'd7;
    cycle();
    rst = 1'b0; tick = 1'b0; cfg_we = 1'b0;
    expect_rr("midrst", 2'd0, 3'd0, 5'd0);
    check("midrst.light", rr_light, 8'h00);
    cycle();
    expect_rr("post_rst_green0", 2'd1, 3'd0, 5'd9);
    do_ticks(10);
    expect_rr("post_rst_yellow", 2'd2, 3'd0, 5'd2);
    do_ticks(3);
    expect_rr("post_rst_allred", 2'd3, 3'd0, 5'd0);
    do_ticks(15);
    expect_rr("post_rst_green2", 2'd1, 3'd2, 5'd9);

    // Demand skipping.
    run = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0; run = 1'b1; demand = 4'b1000;
    cycle();
    expect_sk("skip_start", 2'd1, 3'd0, 5'd9);
    do_ticks(14);
    expect_sk("skip_to3", 2'd1, 3'd3, 5'd9);
    expect_rr("rr_to1", 2'd1, 3'd1, 5'd9);
    demand = 4'b0000;
    do_ticks(14);
    expect_sk("no_demand_to0", 2'd1, 3'd0, 5'd9);
    demand = 4'b0001;
    do_ticks(14);
    expect_sk("self_last", 2'd1, 3'd0, 5'd9);
    expect_rr("rr_to3", 2'd1, 3'd3, 5'd9);
    demand = 4'b0000;

    // Stop after three green ticks, then restart.
    do_ticks(3);
    expect_sk("stop_pre", 2'd1, 3'd0, 5'd6);
    run = 1'b0;
    do_ticks(1);
    expect_sk("stop_yellow", 2'd2, 3'd0, 5'd2);
    do_ticks(3);
    expect_sk("stop_allred", 2'd3, 3'd0, 5'd0);
    do_ticks(1);
    expect_sk("stop_idle", 2'd0, 3'd1, 5'd0);
    expect_rr("rr_stop_idle", 2'd0, 3'd0, 5'd0);
    do_ticks(2);
    expect_sk("idle_tick_ignored", 2'd0, 3'd1, 5'd0);
    run = 1'b1;
    cycle();
    expect_sk("restart", 2'd1, 3'd1, 5'd9);
    expect_rr("rr_restart", 2'd1, 3'd0, 5'd9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
